// File: rtl/mips_control.sv
// Main decoder for the MIPS32 subset core.
// Instruction fields in, registered datapath controls out.
module mips_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] hint,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [5:0] alu_op,
  output logic       alu_src,
  output logic [2:0] dm_op,
  output logic       dm_wr,
  output logic       dm_rd,
  output logic [1:0] ext_op,
  output logic [3:0] pc_op,
  output logic [1:0] reg_src,
  output logic [1:0] reg_dst,
  output logic       reg_wr,
  output logic       reg_in
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] ALU_ADD    = 6'h20;
  localparam logic [5:0] ALU_ADDU   = 6'h21;
  localparam logic [5:0] ALU_SUBU   = 6'h23;
  localparam logic [5:0] ALU_PASSB  = 6'h3F;

  logic [5:0] alu_op_d,  alu_op_q;
  logic       alu_src_d, alu_src_q;
  logic [2:0] dm_op_d,   dm_op_q;
  logic       dm_wr_d,   dm_wr_q;
  logic       dm_rd_d,   dm_rd_q;
  logic [1:0] ext_op_d,  ext_op_q;
  logic [3:0] pc_op_d,   pc_op_q;
  logic [1:0] reg_src_d, reg_src_q;
  logic [1:0] reg_dst_d, reg_dst_q;
  logic       reg_wr_d,  reg_wr_q;
  logic       reg_in_d,  reg_in_q;

  logic is_load, is_store, is_imm;

  always_comb begin
    alu_op_d  = '0;
    alu_src_d = 1'b0;
    dm_op_d   = '0;
    dm_wr_d   = 1'b0;
    dm_rd_d   = 1'b0;
    ext_op_d  = '0;
    pc_op_d   = '0;
    reg_src_d = '0;
    reg_dst_d = '0;
    reg_wr_d  = 1'b0;
    reg_in_d  = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_imm    = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          6'h00, 6'h02, 6'h03: begin
            alu_op_d  = funct;
            reg_dst_d = 2'd1;
            reg_wr_d  = 1'b1;
            reg_in_d  = 1'b1;
          end
          6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            if (~|hint) begin
              alu_op_d  = funct;
              reg_dst_d = 2'd1;
              reg_wr_d  = 1'b1;
            end
          end
          6'h08: begin
            if (rt == '0 && rd == '0 && hint == '0)
              pc_op_d = 4'd2;
          end
          6'h09: begin
            if (rt == '0 && hint == '0) begin
              pc_op_d   = 4'd2;
              reg_src_d = 2'd2;
              reg_dst_d = 2'd1;
              reg_wr_d  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (rt == 5'd0)      pc_op_d = 4'd7;
        else if (rt == 5'd1) pc_op_d = 4'd8;
      end
      OP_J: pc_op_d = 4'd1;
      OP_JAL: begin
        pc_op_d   = 4'd1;
        reg_src_d = 2'd2;
        reg_dst_d = 2'd2;
        reg_wr_d  = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        if (opcode[1] == 1'b0 || rt == '0) begin
          pc_op_d  = {2'b00, opcode[1:0]} + 4'd3;
          alu_op_d = ALU_SUBU;
          ext_op_d = 2'd1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        is_imm   = 1'b1;
        ext_op_d = 2'd1;
        case (opcode[1:0])
          2'd0:    alu_op_d = ALU_ADD;
          2'd1:    alu_op_d = ALU_ADDU;
          2'd2:    alu_op_d = 6'h2A;
          default: alu_op_d = 6'h2B;
        endcase
      end
      OP_ANDI: begin is_imm = 1'b1; alu_op_d = 6'h24; end
      OP_ORI:  begin is_imm = 1'b1; alu_op_d = 6'h25; end
      OP_XORI: begin is_imm = 1'b1; alu_op_d = 6'h26; end
      OP_LUI: begin
        if (rs == '0) begin
          is_imm   = 1'b1;
          alu_op_d = ALU_PASSB;
          ext_op_d = 2'd2;
        end
      end
      OP_LW:  begin is_load = 1'b1; dm_op_d = 3'd0; end
      OP_LB:  begin is_load = 1'b1; dm_op_d = 3'd1; end
      OP_LBU: begin is_load = 1'b1; dm_op_d = 3'd2; end
      OP_LH:  begin is_load = 1'b1; dm_op_d = 3'd3; end
      OP_LHU: begin is_load = 1'b1; dm_op_d = 3'd4; end
      OP_SW:  begin is_store = 1'b1; dm_op_d = 3'd0; end
      OP_SB:  begin is_store = 1'b1; dm_op_d = 3'd1; end
      OP_SH:  begin is_store = 1'b1; dm_op_d = 3'd3; end
      default: ;
    endcase
    if (is_imm) begin
      alu_src_d = 1'b1;
      reg_wr_d  = 1'b1;
    end
    if (is_load || is_store) begin
      alu_op_d  = ALU_ADDU;
      alu_src_d = 1'b1;
      ext_op_d  = 2'd1;
    end
    if (is_load) begin
      dm_rd_d   = 1'b1;
      reg_src_d = 2'd1;
      reg_wr_d  = 1'b1;
    end
    dm_wr_d = is_store;
    // writes to r0 are dropped; the link register r31 is never r0
    if ((reg_dst_d == 2'd0 && rt == '0) ||
        (reg_dst_d == 2'd1 && rd == '0))
      reg_wr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      dm_op_q   <= '0;
      dm_wr_q   <= 1'b0;
      dm_rd_q   <= 1'b0;
      ext_op_q  <= '0;
      pc_op_q   <= '0;
      reg_src_q <= '0;
      reg_dst_q <= '0;
      reg_wr_q  <= 1'b0;
      reg_in_q  <= 1'b0;
    end else begin
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      dm_op_q   <= dm_op_d;
      dm_wr_q   <= dm_wr_d;
      dm_rd_q   <= dm_rd_d;
      ext_op_q  <= ext_op_d;
      pc_op_q   <= pc_op_d;
      reg_src_q <= reg_src_d;
      reg_dst_q <= reg_dst_d;
      reg_wr_q  <= reg_wr_d;
      reg_in_q  <= reg_in_d;
    end
  end

  assign alu_op  = alu_op_q;
  assign alu_src = alu_src_q;
  assign dm_op   = dm_op_q;
  assign dm_wr   = dm_wr_q;
  assign dm_rd   = dm_rd_q;
  assign ext_op  = ext_op_q;
  assign pc_op   = pc_op_q;
  assign reg_src = reg_src_q;
  assign reg_dst = reg_dst_q;
  assign reg_wr  = reg_wr_q;
  assign reg_in  = reg_in_q;

endmodule

// File: tb/tb_mips_control.sv
// Directed-vector bench for mips_control.
// Controls are compared as one packed bundle.
module tb_mips_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic [4:0] shamt, rs, rt, rd;
  logic [5:0] alu_op;
  logic       alu_src;
  logic [2:0] dm_op;
  logic       dm_wr, dm_rd;
  logic [1:0] ext_op;
  logic [3:0] pc_op;
  logic [1:0] reg_src, reg_dst;
  logic       reg_wr, reg_in;

  int n_run = 0;
  int n_fail = 0;

  mips_control dut (
    .clk(clk), .rst(rst),
    .opcode(opcode), .funct(funct), .hint(shamt),
    .rs(rs), .rt(rt), .rd(rd),
    .alu_op(alu_op), .alu_src(alu_src),
    .dm_op(dm_op), .dm_wr(dm_wr), .dm_rd(dm_rd),
    .ext_op(ext_op), .pc_op(pc_op),
    .reg_src(reg_src), .reg_dst(reg_dst),
    .reg_wr(reg_wr), .reg_in(reg_in)
  );

  always #5 clk = ~clk;

  logic [23:0] obs;
  assign obs = {alu_op, alu_src, dm_op, dm_wr, dm_rd, ext_op,
                pc_op, reg_src, reg_dst, reg_wr, reg_in};

  function automatic logic [23:0] ctl(
    input logic [5:0] a, input logic as,
    input logic [2:0] dop, input logic dw, input logic dr,
    input logic [1:0] eo, input logic [3:0] po,
    input logic [1:0] rsrc, input logic [1:0] rdst,
    input logic rw, input logic ri);
    return {a, as, dop, dw, dr, eo, po, rsrc, rdst, rw, ri};
  endfunction

  task automatic chk(input string tag,
                     input logic [23:0] got,
                     input logic [23:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] h, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d);
    @(negedge clk);
    opcode = op; funct = fn; shamt = h;
    rs = s; rt = t; rd = d;
  endtask

  task automatic run(input string tag,
                     input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] h, input logic [4:0] s,
                     input logic [4:0] t, input logic [4:0] d,
                     input logic [23:0] exp);
    drive(op, fn, h, s, t, d);
    @(posedge clk);
    #1 chk(tag, obs, exp);
  endtask

  logic [23:0] e_add, e_jr, e_ori, zero;

  initial begin
    zero  = '0;
    e_add = ctl(6'h20, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    e_jr  = ctl(6'h00, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    e_ori = ctl(6'h25, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    rst = 1'b1;
    opcode = 6'h00; funct = 6'h20; shamt = 0;
    rs = 5'd1; rt = 5'd2; rd = 5'd3;
    #2 chk("reset_zero", obs, zero);
    @(posedge clk); #1 chk("reset_hold", obs, zero);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 chk("add", obs, e_add);

    // one-cycle latency: the new decode shows only after the edge
    drive(6'h00, 6'h08, 0, 5'd5, 0, 0);
    #1 chk("jr_latency", obs, e_add);
    @(posedge clk); #1 chk("jr", obs, e_jr);
    run("jalr", 6'h00, 6'h09, 0, 5'd5, 0, 5'd31,
        ctl(0, 0, 0, 0, 0, 0, 2, 2, 1, 1, 0));
    run("jalr_rd0", 6'h00, 6'h09, 0, 5'd5, 0, 0,
        ctl(0, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0));
    run("jr_bad_rd", 6'h00, 6'h08, 0, 5'd5, 0, 5'd1, zero);
    run("jal", 6'h03, 0, 0, 0, 0, 0,
        ctl(0, 0, 0, 0, 0, 0, 1, 2, 2, 1, 0));
    run("j", 6'h02, 0, 0, 0, 5'd4, 5'd4,
        ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    run("lb", 6'h20, 0, 0, 5'd1, 5'd4, 0,
        ctl(6'h21, 1, 1, 0, 1, 1, 0, 1, 0, 1, 0));
    run("sh", 6'h29, 0, 0, 5'd1, 5'd4, 0,
        ctl(6'h21, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0));
    run("lhu", 6'h25, 0, 0, 5'd1, 5'd3, 0,
        ctl(6'h21, 1, 4, 0, 1, 1, 0, 1, 0, 1, 0));
    run("sw", 6'h2B, 0, 0, 5'd1, 5'd3, 0,
        ctl(6'h21, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    drive(6'h01, 0, 0, 5'd2, 5'd1, 0);
    @(posedge clk);
    #1 chk("bgez_pc", {20'd0, pc_op}, 24'd8);
    drive(6'h01, 0, 0, 5'd2, 5'd0, 0);
    @(posedge clk);
    #1 chk("bltz_pc", {20'd0, pc_op}, 24'd7);
    run("regimm_bad", 6'h01, 0, 0, 5'd2, 5'd5, 0, zero);
    run("bad_op", 6'h3F, 0, 0, 5'd2, 5'd5, 5'd6, zero);
    run("sll_nop", 6'h00, 6'h00, 0, 0, 0, 0,
        ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    run("sra", 6'h00, 6'h03, 5'd7, 0, 5'd2, 5'd9,
        ctl(6'h03, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    run("add_bad_hint", 6'h00, 6'h20, 5'd3, 5'd1, 5'd2, 5'd3, zero);
    run("sltu", 6'h00, 6'h2B, 0, 5'd1, 5'd2, 5'd3,
        ctl(6'h2B, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    run("bad_funct", 6'h00, 6'h01, 0, 5'd1, 5'd2, 5'd3, zero);
    run("beq", 6'h04, 0, 0, 5'd1, 5'd2, 0,
        ctl(6'h23, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    run("bgtz", 6'h07, 0, 0, 5'd1, 0, 0,
        ctl(6'h23, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0));
    run("blez_bad_rt", 6'h06, 0, 0, 5'd1, 5'd1, 0, zero);
    run("lui", 6'h0F, 0, 0, 0, 5'd8, 0,
        ctl(6'h3F, 1, 0, 0, 0, 2, 0, 0, 0, 1, 0));
    run("lui_bad_rs", 6'h0F, 0, 0, 5'd1, 5'd8, 0, zero);
    run("addiu_r0", 6'h09, 0, 0, 5'd1, 0, 0,
        ctl(6'h21, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    run("slti", 6'h0A, 0, 0, 5'd1, 5'd2, 0,
        ctl(6'h2A, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    run("ori", 6'h0D, 0, 0, 5'd1, 5'd7, 0, e_ori);

    // asynchronous reset in the middle of a cycle
    @(negedge clk); #1 rst = 1'b1;
    #1 chk("async_rst", obs, zero);
    @(posedge clk); #1 chk("rst_hold2", obs, zero);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_release", obs, zero);
    @(posedge clk); #1 chk("post_rst", obs, e_ori);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_control.md
Name: mips_control

Overview:
- Main decoder for the single-issue MIPS32 subset CPU.
- Decodes the instruction fields opcode, funct, hint (shamt), rs, rt and rd into datapath control signals.
- Outputs are registered: 1 cycle latency from instruction fields to controls.
- Sits between the instruction fetch/decode register and the ALU, data-memory, extender, PC and register-file muxes.

Parameters:
- None.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- hint  in  5  instr[10:6] (shamt)
- rs  in  5  instr[25:21]
- rt  in  5  instr[20:16]
- rd  in  5  instr[15:11]
- alu_op  out  6  ALU operation code
- alu_src  out  1  ALU B operand: 0=rt reg, 1=extended immediate
- dm_op  out  3  memory access size: 0=W, 1=B signed, 2=BU, 3=H signed, 4=HU
- dm_wr  out  1  data-memory write enable
- dm_rd  out  1  data-memory read enable
- ext_op  out  2  immediate extender: 0=zero, 1=sign, 2=upper (imm<<16)
- pc_op  out  4  next PC: 0=PC+4, 1=J target, 2=rs (register jump), 3=BEQ, 4=BNE, 5=BLEZ, 6=BGTZ, 7=BLTZ, 8=BGEZ
- reg_src  out  2  write-back data: 0=ALU, 1=memory, 2=PC+8 (link)
- reg_dst  out  2  write register: 0=rt, 1=rd, 2=r31
- reg_wr  out  1  register-file write enable
- reg_in  out  1  ALU A operand: 0=rs, 1=hint (shift amount)

Behaviour:
- One clock, clk; reset is asynchronous and active-high (rst).
- While rst=1, every output is 0. This all-zero state is the NOP: PC+4, no writes.
- On each rising clk edge with rst=0, all outputs load the decode of the current input fields.
- Decode is combinational internally; there is no other state.
- Opcodes (hex): SPECIAL 00, REGIMM 01, J 02, JAL 03, BEQ 04, BNE 05, BLEZ 06, BGTZ 07, ADDI 08, ADDIU 09, SLTI 0A, SLTIU 0B, ANDI 0C, ORI 0D, XORI 0E, LUI 0F, LB 20, LH 21, LW 23, LBU 24, LHU 25, SB 28, SH 29, SW 2B.
- SPECIAL funct codes: SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07, JR 08, JALR 09, ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B.
- R-type ALU and shift instructions:
  - alu_op=funct, reg_dst=1, reg_wr=1, reg_src=0, alu_src=0.
  - SLL/SRL/SRA set reg_in=1.
  - Variable shifts and other R-type ALU ops require hint=0; otherwise the instruction decodes as NOP.
- JR: requires rt=0, rd=0, hint=0. pc_op=2, reg_wr=0.
- JALR: requires rt=0, hint=0. pc_op=2, reg_dst=1, reg_src=2, reg_wr=1.
- J: pc_op=1.
- JAL: pc_op=1, reg_dst=2, reg_src=2, reg_wr=1.
- Branches BEQ/BNE/BLEZ/BGTZ: pc_op=3..6, alu_op=23 (SUBU), ext_op=1.
  - BLEZ and BGTZ require rt=0.
- REGIMM: rt=00 gives BLTZ (pc_op=7); rt=01 gives BGEZ (pc_op=8). Any other rt value is NOP.
- I-type ALU instructions: alu_src=1, reg_dst=0, reg_wr=1, reg_src=0.
  - ADDI: alu_op=20, ext_op=1.
  - ADDIU: alu_op=21, ext_op=1.
  - SLTI: alu_op=2A, ext_op=1.
  - SLTIU: alu_op=2B, ext_op=1.
  - ANDI: alu_op=24, ext_op=0.
  - ORI: alu_op=25, ext_op=0.
  - XORI: alu_op=26, ext_op=0.
  - LUI: alu_op=3F (pass B), ext_op=2; requires rs=0.
- Loads: alu_op=21, alu_src=1, ext_op=1, dm_rd=1, reg_src=1, reg_dst=0, reg_wr=1.
  - dm_op: LW→0, LB→1, LBU→2, LH→3, LHU→4.
- Stores: alu_op=21, alu_src=1, ext_op=1, dm_wr=1, reg_wr=0.
  - dm_op: SW→0, SB→1, SH→3.
- Undefined opcode/funct, or a failed field check: all outputs 0.
- reg_wr is forced to 0 when the selected destination register is 0:
  - rt for reg_dst=0, rd for reg_dst=1. r31 (reg_dst=2) is never forced.
- Unlisted outputs are 0 for each instruction.
- Reset asserted mid-stream clears the outputs immediately, without waiting for a clock edge. The first edge after release loads the current decode.

Test Plan:
- rst=1 with any inputs → all outputs 0 asynchronously; release rst, apply opcode=00 funct=20 rd=3 hint=0, clock once → alu_op=20, reg_dst=1, reg_wr=1, alu_src=0, pc_op=0.
- SPECIAL funct=08 rs=5 rt=0 rd=0, then funct=09 rd=31 → JR: pc_op=2, reg_wr=0; JALR: pc_op=2, reg_src=2, reg_dst=1, reg_wr=1; each value appears one clock after its input.
- opcode=03 → pc_op=1, reg_dst=2, reg_src=2, reg_wr=1.
- opcode=20 rt=4 → dm_rd=1, dm_op=1, reg_src=1, alu_src=1, ext_op=1, alu_op=21, reg_wr=1. Then opcode=29 → dm_wr=1, dm_op=3, reg_wr=0, dm_rd=0.
- opcode=01 rt=01 → pc_op=8; rt=05 → all outputs 0. Then opcode=3F → all outputs 0.
- opcode=00 funct=00 rd=0 (NOP SLL) → reg_wr=0, reg_in=1. Then ORI (opcode=0D) rt=7 → ext_op=0, alu_op=25, alu_src=1, reg_wr=1.
